// File: rtl/steuerwerk.sv
// steuerwerk: multi-cycle fetch/decode/ALU/writeback sequencer with phase timers,
// instruction-boundary halt and retired-instruction counter.
// Optional memory-handshake watchdog: define STEUERWERK_WATCHDOG_EN.
module steuerwerk #(
  parameter int RESETTIME         = 3,
  parameter int DECODETIME        = 4,
  parameter int ALUTIME           = 3,
  parameter int REGISTERWRITETIME = 2,
  parameter int PCWRITETIME       = 1,
  parameter int CNT_W             = 4,
  parameter int ZAEHLER_W         = 32,
  parameter int TIMEOUT           = 255
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 LoadBefehl,
  input  logic                 StoreBefehl,
  input  logic                 JALBefehl,
  input  logic                 UnbedingterSprungBefehl,
  input  logic                 BedingterSprungBefehl,
  input  logic                 Bedingung,
  input  logic                 BefehlGeladen,
  input  logic                 DatenGeladen,
  input  logic                 DatenGespeichert,
  input  logic                 Halt,
  output logic                 RegisterSchreibSignal,
  output logic                 ALUStartSignal,
  output logic                 ALUSchreibSignal,
  output logic                 LoadBefehlSignal,
  output logic                 LoadDatenSignal,
  output logic                 StoreDatenSignal,
  output logic                 PCSignal,
  output logic                 DekodierSignal,
  output logic                 ResetSignal,
  output logic                 PCSprungSignal,
  output logic                 Angehalten,
  output logic                 Fehler,
  output logic [3:0]           Zustand,
  output logic [ZAEHLER_W-1:0] BefehlsZaehler
);

  typedef enum logic [3:0] {
    RESET_WAIT = 4'd0,
    FETCH      = 4'd1,
    DECODE     = 4'd2,
    ALU_1      = 4'd3,
    ALU_2      = 4'd4,
    WB_JUMP    = 4'd5,
    WB_STORE   = 4'd6,
    WB_LOAD    = 4'd7,
    WB_REG     = 4'd8,
    HALT       = 4'd9,
    FEHLER     = 4'd10
  } state_e;

  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RESETTIME - 1);
  localparam logic [CNT_W-1:0] DEC_LD = CNT_W'(DECODETIME - 1);
  localparam logic [CNT_W-1:0] ALU_LD = CNT_W'(ALUTIME - 1);
  localparam logic [CNT_W-1:0] REG_LD = CNT_W'(REGISTERWRITETIME - 1);
  localparam logic [CNT_W-1:0] PC_LD  = CNT_W'(PCWRITETIME - 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ZAEHLER_W-1:0]   zaehler_q;
  logic rst_q, ldb_q, dek_q, alu_q, aluw_q, reg_q, pc_q, ldd_q, std_q;
  logic jump, wb_exit, wd_expire;

  assign jump    = UnbedingterSprungBefehl | BedingterSprungBefehl;
  assign wb_exit = ((state_q == WB_JUMP || state_q == WB_REG) && cnt_q == '0) ||
                   (state_q == WB_STORE && DatenGespeichert);

`ifdef STEUERWERK_WATCHDOG_EN
  logic [15:0] wcnt_q;
  logic        waiting;

  always_comb begin
    waiting = 1'b0;
    case (state_q)
      FETCH:    waiting = !BefehlGeladen;
      WB_STORE: waiting = !DatenGespeichert;
      WB_LOAD:  waiting = !DatenGeladen;
      default:  waiting = 1'b0;
    endcase
  end

  // A handshake (or any non-waiting state) clears the count, so every entry starts at 0.
  assign wd_expire = waiting && (({1'b0, wcnt_q} + 17'd1) == 17'(TIMEOUT));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)         wcnt_q <= '0;
    else if (!waiting) wcnt_q <= '0;
    else               wcnt_q <= wcnt_q + 16'd1;
  end

  assign Fehler = (state_q == FEHLER);
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
  assign wd_expire      = 1'b0;
  assign Fehler         = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= RESET_WAIT;
      cnt_q     <= RST_LD;
      zaehler_q <= '0;
      rst_q     <= 1'b1;
      ldb_q     <= 1'b0;
      dek_q     <= 1'b0;
      alu_q     <= 1'b0;
      aluw_q    <= 1'b0;
      reg_q     <= 1'b0;
      pc_q      <= 1'b0;
      ldd_q     <= 1'b0;
      std_q     <= 1'b0;
    end else if (wd_expire) begin
      state_q <= FEHLER;
      ldb_q   <= 1'b0;
      pc_q    <= 1'b0;
      ldd_q   <= 1'b0;
      std_q   <= 1'b0;
    end else if (wb_exit) begin
      pc_q      <= 1'b0;
      reg_q     <= 1'b0;
      std_q     <= 1'b0;
      zaehler_q <= zaehler_q + 1'b1;
      if (Halt) begin
        state_q <= HALT;
      end else begin
        state_q <= FETCH;
        ldb_q   <= 1'b1;
      end
    end else begin
      case (state_q)
        RESET_WAIT: begin
          if (cnt_q == '0) begin
            rst_q   <= 1'b0;
            ldb_q   <= 1'b1;
            state_q <= FETCH;
          end else cnt_q <= cnt_q - 1'b1;
        end
        FETCH: begin
          if (BefehlGeladen) begin
            ldb_q   <= 1'b0;
            dek_q   <= 1'b1;
            cnt_q   <= DEC_LD;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (cnt_q == '0) begin
            dek_q   <= 1'b0;
            alu_q   <= 1'b1;
            reg_q   <= JALBefehl;
            cnt_q   <= ALU_LD;
            state_q <= ALU_1;
          end else cnt_q <= cnt_q - 1'b1;
        end
        ALU_1: begin
          if (cnt_q == '0) begin
            alu_q   <= 1'b0;
            aluw_q  <= 1'b1;
            state_q <= ALU_2;
          end else cnt_q <= cnt_q - 1'b1;
        end
        ALU_2: begin
          aluw_q <= 1'b0;
          reg_q  <= 1'b0;
          pc_q   <= 1'b1;
          if (jump) begin
            cnt_q   <= PC_LD;
            state_q <= WB_JUMP;
          end else if (StoreBefehl) begin
            std_q   <= 1'b1;
            state_q <= WB_STORE;
          end else if (LoadBefehl) begin
            ldd_q   <= 1'b1;
            state_q <= WB_LOAD;
          end else begin
            reg_q   <= 1'b1;
            cnt_q   <= REG_LD;
            state_q <= WB_REG;
          end
        end
        WB_JUMP, WB_REG: cnt_q <= cnt_q - 1'b1;
        WB_LOAD: begin
          // PCSignal deliberately stays high into the register writeback
          if (DatenGeladen) begin
            ldd_q   <= 1'b0;
            reg_q   <= 1'b1;
            cnt_q   <= REG_LD;
            state_q <= WB_REG;
          end
        end
        HALT: begin
          if (!Halt) begin
            ldb_q   <= 1'b1;
            state_q <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  assign ResetSignal           = rst_q;
  assign LoadBefehlSignal      = ldb_q;
  assign DekodierSignal        = dek_q;
  assign ALUStartSignal        = alu_q;
  assign ALUSchreibSignal      = aluw_q;
  assign RegisterSchreibSignal = reg_q;
  assign PCSignal              = pc_q;
  assign LoadDatenSignal       = ldd_q;
  assign StoreDatenSignal      = std_q;
  assign PCSprungSignal        = UnbedingterSprungBefehl | (BedingterSprungBefehl & Bedingung);
  assign Angehalten            = (state_q == HALT);
  assign Zustand               = state_q;
  assign BefehlsZaehler        = zaehler_q;

endmodule

// File: tb/tb_steuerwerk.sv
// Directed bench for steuerwerk: strobe lengths/ordering per instruction class,
// halt, mid-instruction reset and handshake wait (watchdog or unbounded).
module tb_steuerwerk;
  localparam int ZW = 32;
  localparam int S_RST = 0, S_LDB = 1, S_DEK = 2, S_ALU = 3, S_ALUW = 4,
                 S_REG = 5, S_PC = 6, S_LDD = 7, S_STD = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic LoadBefehl, StoreBefehl, JALBefehl, UnbedingterSprungBefehl, BedingterSprungBefehl, Bedingung;
  logic BefehlGeladen, DatenGeladen, DatenGespeichert, Halt;
  logic RegisterSchreibSignal, ALUStartSignal, ALUSchreibSignal, LoadBefehlSignal, LoadDatenSignal;
  logic StoreDatenSignal, PCSignal, DekodierSignal, ResetSignal, PCSprungSignal, Angehalten, Fehler;
  logic [3:0]    Zustand;
  logic [ZW-1:0] BefehlsZaehler;

  int n_checks = 0;
  int n_fail   = 0;
  int hi[9], first[9], last[9];
  int ncyc;
  bit tmo;
  bit halt_at_alu = 1'b0;
  int load_lat    = 0;

  steuerwerk #(.TIMEOUT(8)) dut (
    .Clock(Clock), .Reset(Reset),
    .LoadBefehl(LoadBefehl), .StoreBefehl(StoreBefehl), .JALBefehl(JALBefehl),
    .UnbedingterSprungBefehl(UnbedingterSprungBefehl), .BedingterSprungBefehl(BedingterSprungBefehl),
    .Bedingung(Bedingung), .BefehlGeladen(BefehlGeladen), .DatenGeladen(DatenGeladen),
    .DatenGespeichert(DatenGespeichert), .Halt(Halt),
    .RegisterSchreibSignal(RegisterSchreibSignal), .ALUStartSignal(ALUStartSignal),
    .ALUSchreibSignal(ALUSchreibSignal), .LoadBefehlSignal(LoadBefehlSignal),
    .LoadDatenSignal(LoadDatenSignal), .StoreDatenSignal(StoreDatenSignal), .PCSignal(PCSignal),
    .DekodierSignal(DekodierSignal), .ResetSignal(ResetSignal), .PCSprungSignal(PCSprungSignal),
    .Angehalten(Angehalten), .Fehler(Fehler), .Zustand(Zustand), .BefehlsZaehler(BefehlsZaehler)
  );

  always #5 Clock = ~Clock;

  function automatic logic [8:0] strobes();
    return {StoreDatenSignal, LoadDatenSignal, PCSignal, RegisterSchreibSignal, ALUSchreibSignal,
            ALUStartSignal, DekodierSignal, LoadBefehlSignal, ResetSignal};
  endfunction

  // Samples strobes once per negedge until the retired count hits target; drives DatenGeladen/Halt.
  task automatic measure(input logic [ZW-1:0] target, input int budget);
    logic [8:0] s;
    int lrun;
    lrun = 0; ncyc = 0; tmo = 1'b0;
    for (int k = 0; k < 9; k++) begin hi[k] = 0; first[k] = -1; last[k] = -1; end
    while (BefehlsZaehler !== target) begin
      if (ncyc >= budget) begin tmo = 1'b1; break; end
      s = strobes();
      for (int k = 0; k < 9; k++)
        if (s[k]) begin hi[k]++; if (first[k] < 0) first[k] = ncyc; last[k] = ncyc; end
      lrun = LoadDatenSignal ? lrun + 1 : 0;
      DatenGeladen = (load_lat > 0) && (lrun == load_lat);
      if (halt_at_alu && Zustand == 4'd3) Halt = 1'b1;
      @(negedge Clock);
      ncyc++;
    end
    DatenGeladen = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    n_checks++; if (Zustand !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", Zustand); end
    n_checks++; if (strobes() !== 9'b000000001) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000000001", strobes()); end
    n_checks++; if (BefehlsZaehler !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", BefehlsZaehler); end
    n_checks++; if (Angehalten !== 1'b0 || Fehler !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b expected 00", Angehalten, Fehler); end
  endtask

  task automatic test_basic();
    int exp_hi[9]    = '{3, 1, 4, 3, 1, 2, 2, 0, 0};
    int exp_first[9] = '{0, 3, 4, 8, 11, 12, 12, -1, -1};
    Reset = 1'b0;
    measure(32'd1, 40);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL basic_timeout: got timeout expected retire"); end
    for (int k = 0; k < 9; k++) begin
      n_checks++; if (hi[k] !== exp_hi[k]) begin n_fail++; $display("FAIL basic_len[%0d]: got %0d expected %0d", k, hi[k], exp_hi[k]); end
      n_checks++; if (first[k] !== exp_first[k]) begin n_fail++; $display("FAIL basic_start[%0d]: got %0d expected %0d", k, first[k], exp_first[k]); end
    end
    n_checks++; if (ncyc - first[S_LDB] !== 11) begin n_fail++; $display("FAIL basic_cycles: got %0d expected 11", ncyc - first[S_LDB]); end
  endtask

  task automatic test_load();
    int exp_hi[9]    = '{0, 1, 4, 3, 1, 2, 7, 5, 0};
    int exp_first[9] = '{-1, 0, 1, 5, 8, 14, 9, 9, -1};
    LoadBefehl = 1'b1; load_lat = 5;
    measure(32'd2, 60);
    LoadBefehl = 1'b0; load_lat = 0;
    n_checks++; if (tmo) begin n_fail++; $display("FAIL load_timeout: got timeout expected retire"); end
    for (int k = 0; k < 9; k++) begin
      n_checks++; if (hi[k] !== exp_hi[k]) begin n_fail++; $display("FAIL load_len[%0d]: got %0d expected %0d", k, hi[k], exp_hi[k]); end
      n_checks++; if (first[k] !== exp_first[k]) begin n_fail++; $display("FAIL load_start[%0d]: got %0d expected %0d", k, first[k], exp_first[k]); end
    end
    n_checks++; if (last[S_PC] !== 15) begin n_fail++; $display("FAIL load_pc_end: got %0d expected 15", last[S_PC]); end
    n_checks++; if (ncyc !== 16) begin n_fail++; $display("FAIL load_cycles: got %0d expected 16", ncyc); end
  endtask

  task automatic test_jal();
    int exp_hi[9]    = '{0, 1, 4, 3, 1, 4, 1, 0, 0};
    int exp_first[9] = '{-1, 0, 1, 5, 8, 5, 9, -1, -1};
    JALBefehl = 1'b1; UnbedingterSprungBefehl = 1'b1;
    measure(32'd3, 40);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL jal_timeout: got timeout expected retire"); end
    for (int k = 0; k < 9; k++) begin
      n_checks++; if (hi[k] !== exp_hi[k]) begin n_fail++; $display("FAIL jal_len[%0d]: got %0d expected %0d", k, hi[k], exp_hi[k]); end
      n_checks++; if (first[k] !== exp_first[k]) begin n_fail++; $display("FAIL jal_start[%0d]: got %0d expected %0d", k, first[k], exp_first[k]); end
    end
    n_checks++; if (ncyc !== 10) begin n_fail++; $display("FAIL jal_cycles: got %0d expected 10", ncyc); end
    #1;
    n_checks++; if (PCSprungSignal !== 1'b1) begin n_fail++; $display("FAIL jump_uncond: got %b expected 1", PCSprungSignal); end
    JALBefehl = 1'b0; UnbedingterSprungBefehl = 1'b0; BedingterSprungBefehl = 1'b1; Bedingung = 1'b0; #1;
    n_checks++; if (PCSprungSignal !== 1'b0) begin n_fail++; $display("FAIL jump_cond_false: got %b expected 0", PCSprungSignal); end
    Bedingung = 1'b1; #1;
    n_checks++; if (PCSprungSignal !== 1'b1) begin n_fail++; $display("FAIL jump_cond_true: got %b expected 1", PCSprungSignal); end
    BedingterSprungBefehl = 1'b0; Bedingung = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_halt();
    halt_at_alu = 1'b1;
    measure(32'd4, 40);
    halt_at_alu = 1'b0;
    n_checks++; if (tmo) begin n_fail++; $display("FAIL halt_timeout: got timeout expected retire"); end
    n_checks++; if (hi[S_REG] !== 2) begin n_fail++; $display("FAIL halt_completes: got %0d expected 2", hi[S_REG]); end
    n_checks++; if (Angehalten !== 1'b1 || Zustand !== 4'd9) begin n_fail++; $display("FAIL halt_enter: got %b/%0d expected 1/9", Angehalten, Zustand); end
    n_checks++; if (strobes() !== 9'b0) begin n_fail++; $display("FAIL halt_strobes: got %b expected 000000000", strobes()); end
    repeat (3) @(negedge Clock);
    n_checks++; if (Angehalten !== 1'b1 || LoadBefehlSignal !== 1'b0) begin n_fail++; $display("FAIL halt_hold: got %b/%b expected 1/0", Angehalten, LoadBefehlSignal); end
    Halt = 1'b0;
    @(negedge Clock);
    n_checks++; if (Zustand !== 4'd1 || LoadBefehlSignal !== 1'b1 || Angehalten !== 1'b0) begin
      n_fail++; $display("FAIL halt_resume: got %0d/%b/%b expected 1/1/0", Zustand, LoadBefehlSignal, Angehalten);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10 && Zustand !== 4'd2; i++) @(negedge Clock);
    n_checks++; if (Zustand !== 4'd2 || DekodierSignal !== 1'b1) begin n_fail++; $display("FAIL mid_reach_decode: got %0d/%b expected 2/1", Zustand, DekodierSignal); end
    n_checks++; if (BefehlsZaehler !== 32'd4) begin n_fail++; $display("FAIL mid_count_before: got %0d expected 4", BefehlsZaehler); end
    Reset = 1'b1;
    #1;
    n_checks++; if (Zustand !== 4'd0) begin n_fail++; $display("FAIL mid_state: got %0d expected 0", Zustand); end
    n_checks++; if (strobes() !== 9'b000000001) begin n_fail++; $display("FAIL mid_strobes: got %b expected 000000001", strobes()); end
    n_checks++; if (BefehlsZaehler !== '0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", BefehlsZaehler); end
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_store_wait();
    int n;
    StoreBefehl = 1'b1; DatenGespeichert = 1'b0;
    for (int i = 0; i < 40 && Zustand !== 4'd6; i++) @(negedge Clock);
    n_checks++; if (Zustand !== 4'd6) begin n_fail++; $display("FAIL store_reach: got %0d expected 6", Zustand); end
    n = 0;
`ifdef STEUERWERK_WATCHDOG_EN
    while (Zustand === 4'd6 && n < 50) begin n++; @(negedge Clock); end
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL wd_wait_cycles: got %0d expected 8", n); end
    n_checks++; if (Fehler !== 1'b1 || Zustand !== 4'd10) begin n_fail++; $display("FAIL wd_fehler: got %b/%0d expected 1/10", Fehler, Zustand); end
    n_checks++; if (strobes() !== 9'b0) begin n_fail++; $display("FAIL wd_strobes: got %b expected 000000000", strobes()); end
    DatenGespeichert = 1'b1;
    repeat (3) @(negedge Clock);
    DatenGespeichert = 1'b0;
    n_checks++; if (Fehler !== 1'b1 || Zustand !== 4'd10) begin n_fail++; $display("FAIL wd_sticky: got %b/%0d expected 1/10", Fehler, Zustand); end
`else
    while (Zustand === 4'd6 && n < 1000) begin n++; @(negedge Clock); end
    n_checks++; if (n !== 1000) begin n_fail++; $display("FAIL store_wait_cycles: got %0d expected 1000", n); end
    n_checks++; if (Fehler !== 1'b0 || StoreDatenSignal !== 1'b1) begin n_fail++; $display("FAIL store_waiting: got %b/%b expected 0/1", Fehler, StoreDatenSignal); end
    DatenGespeichert = 1'b1;
    @(negedge Clock);
    DatenGespeichert = 1'b0;
    n_checks++; if (Zustand !== 4'd1 || StoreDatenSignal !== 1'b0 || PCSignal !== 1'b0) begin
      n_fail++; $display("FAIL store_exit: got %0d/%b/%b expected 1/0/0", Zustand, StoreDatenSignal, PCSignal);
    end
    n_checks++; if (BefehlsZaehler !== 32'd1) begin n_fail++; $display("FAIL store_count: got %0d expected 1", BefehlsZaehler); end
`endif
    StoreBefehl = 1'b0;
  endtask

  initial begin
    LoadBefehl = 1'b0; StoreBefehl = 1'b0; JALBefehl = 1'b0; UnbedingterSprungBefehl = 1'b0;
    BedingterSprungBefehl = 1'b0; Bedingung = 1'b0; BefehlGeladen = 1'b1; DatenGeladen = 1'b0;
    DatenGespeichert = 1'b0; Halt = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_load();
    test_jal();
    test_halt();
    test_reset_mid();
    test_store_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
